// File: rtl/alu_pkg.sv
// Shared opcode constants and controller state encoding for the sequential ALU.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_AND = 4'b0001;
    localparam logic [3:0] OP_OR  = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_SLT = 4'b0101;
    localparam logic [3:0] OP_SLL = 4'b0110;
    localparam logic [3:0] OP_SRL = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles per product.
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] mcand_q, mplier_q, acc_q, acc_nxt;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;

    assign acc_nxt = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    // done flags the final iteration so the product is taken on the same edge it completes
    assign done    = busy_q && (cnt_q == CW'(1));
    assign product = acc_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (start) begin
            mcand_q  <= a;
            mplier_q <= b;
            acc_q    <= '0;
            cnt_q    <= CW'(WIDTH);
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            acc_q    <= acc_nxt;
            cnt_q    <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq_core.sv
// Handshaked ALU: single-cycle ops complete on accept, MUL runs through alu_mul_iter.
// state   | meaning
// IDLE    | ready for a new operation
// MUL     | multiplier iterating
// DONE    | result valid, waiting for out_ready
module alu_seq_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUControl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Carry,
    output logic             Overflow,
    output logic             Negative
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q;
    logic             zero_q, carry_q, ovf_q, neg_q, out_valid_q;

    logic             accept, load_alu, load_mul, mul_start, mul_done;
    logic [WIDTH-1:0] mul_product;
    logic [WIDTH:0]   sum, diff;
    logic             add_ovf, sub_ovf;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v;

    assign accept    = in_valid && (state_q == ST_IDLE);
    assign mul_start = accept && (ALUControl == OP_MUL);

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (A),
        .b       (B),
        .done    (mul_done),
        .product (mul_product)
    );

    assign sum     = {1'b0, A} + {1'b0, B};
    assign diff    = {1'b0, A} - {1'b0, B};
    assign add_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
    assign sub_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (ALUControl)
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = add_ovf;
            end
            OP_AND: alu_res = A & B;
            OP_OR:  alu_res = A | B;
            OP_XOR: alu_res = A ^ B;
            OP_SUB: begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = diff[WIDTH];
                alu_v   = sub_ovf;
            end
            // signed less-than is the sign of the difference corrected by overflow
            OP_SLT: begin
                alu_res = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ sub_ovf};
                alu_c   = diff[WIDTH];
            end
            OP_SLL: alu_res = A << B[SHW-1:0];
            OP_SRL: alu_res = A >> B[SHW-1:0];
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = (ALUControl == OP_MUL) ? ST_MUL : ST_DONE;
            ST_MUL:  if (mul_done) state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == ST_IDLE);
        load_alu = accept && (ALUControl != OP_MUL);
        load_mul = (state_q == ST_MUL) && mul_done;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q    <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            neg_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= (state_d == ST_DONE);
            if (load_alu) begin
                result_q <= alu_res;
                zero_q   <= (alu_res == '0);
                neg_q    <= alu_res[WIDTH-1];
                carry_q  <= alu_c;
                ovf_q    <= alu_v;
            end else if (load_mul) begin
                result_q <= mul_product;
                zero_q   <= (mul_product == '0);
                neg_q    <= mul_product[WIDTH-1];
                carry_q  <= 1'b0;
                ovf_q    <= 1'b0;
            end
        end
    end

    assign Result    = result_q;
    assign Zero      = zero_q;
    assign Carry     = carry_q;
    assign Overflow  = ovf_q;
    assign Negative  = neg_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_seq_core.sv
// Directed self-checking bench for alu_seq_core at WIDTH=32.
module tb_alu_seq_core;

    logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] A, B, Result;
    logic [3:0]  ALUControl;
    logic        Zero, Carry, Overflow, Negative;
    int          checks = 0;
    int          errors = 0;

    alu_seq_core #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .ALUControl(ALUControl), .out_valid(out_valid),
        .out_ready(out_ready), .Result(Result), .Zero(Zero), .Carry(Carry),
        .Overflow(Overflow), .Negative(Negative)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // drives a request at posedge+1 and returns just after the accepting edge
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int guard;
        ALUControl = op; A = a; B = b; in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1; guard++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; A = '1; B = '1; ALUControl = 4'b1111;
    endtask

    // lat counts the accepting edge as cycle 1; capped at 100
    task automatic wait_done(output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; ALUControl = '0;
        #12;
        checks++;
        if ({out_valid, Result, Zero, Carry, Overflow, Negative} !== 37'd0) begin
            errors++; $display("FAIL reset_outputs: got %h required 0", {out_valid, Result, Zero, Carry, Overflow, Negative});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready);
        end
    endtask

    task automatic test_add_carry();
        int lat;
        issue(4'b0000, 32'hFFFFFFFF, 32'h1);
        wait_done(lat);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL add_latency: got %0d required 1", lat); end
        checks++;
        if (Result !== 32'h0 || {Zero, Carry, Overflow, Negative} !== 4'b1100) begin
            errors++; $display("FAIL add_carry: got R=%h ZCVN=%b required R=0 ZCVN=1100", Result, {Zero, Carry, Overflow, Negative});
        end
        release_out();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL add_release: got ov=%b ir=%b required ov=0 ir=1", out_valid, in_ready);
        end
    endtask

    task automatic test_sub_slt();
        int lat;
        issue(4'b0100, 32'h80000000, 32'h1);
        wait_done(lat);
        checks++;
        if (Result !== 32'h7FFFFFFF || {Zero, Carry, Overflow, Negative} !== 4'b0010) begin
            errors++; $display("FAIL sub_ovf: got R=%h ZCVN=%b required R=7fffffff ZCVN=0010", Result, {Zero, Carry, Overflow, Negative});
        end
        release_out();
        issue(4'b0101, 32'hFFFFFFFF, 32'h1);
        wait_done(lat);
        checks++;
        if (Result !== 32'h1 || {Zero, Carry, Overflow, Negative} !== 4'b0000) begin
            errors++; $display("FAIL slt_signed: got R=%h ZCVN=%b required R=1 ZCVN=0000", Result, {Zero, Carry, Overflow, Negative});
        end
        release_out();
        issue(4'b0100, 32'h1, 32'h2);
        wait_done(lat);
        checks++;
        if (Result !== 32'hFFFFFFFF || {Zero, Carry, Overflow, Negative} !== 4'b0101) begin
            errors++; $display("FAIL sub_borrow: got R=%h ZCVN=%b required R=ffffffff ZCVN=0101", Result, {Zero, Carry, Overflow, Negative});
        end
        release_out();
    endtask

    task automatic test_logic_shift();
        logic [3:0]  ops [6]  = '{4'b0010, 4'b0011, 4'b0111, 4'b0111, 4'b0110, 4'b1111};
        logic [31:0] as  [6]  = '{32'h0F0F0000, 32'hFFFF0000, 32'h80000000, 32'h12345678, 32'h1, 32'hFFFFFFFF};
        logic [31:0] bs  [6]  = '{32'h000000FF, 32'h0F0F0F0F, 32'h4, 32'h20, 32'd31, 32'hFFFFFFFF};
        logic [31:0] exr [6]  = '{32'h0F0F00FF, 32'hF0F00F0F, 32'h08000000, 32'h12345678, 32'h80000000, 32'h0};
        logic [3:0]  exf [6]  = '{4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b1000};
        int lat;
        for (int i = 0; i < 6; i++) begin
            issue(ops[i], as[i], bs[i]);
            wait_done(lat);
            checks++;
            if (lat !== 1 || Result !== exr[i] || {Zero, Carry, Overflow, Negative} !== exf[i]) begin
                errors++;
                $display("FAIL logic_shift[%0d]: got lat=%0d R=%h ZCVN=%b required lat=1 R=%h ZCVN=%b",
                         i, lat, Result, {Zero, Carry, Overflow, Negative}, exr[i], exf[i]);
            end
            release_out();
        end
    endtask

    task automatic test_mul();
        int lat;
        int ready_seen;
        ALUControl = 4'b1000; A = 32'd12345; B = 32'd678; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; A = '1; B = '1;
        lat = 1; ready_seen = 0;
        while (!out_valid && lat < 100) begin
            if (in_ready) ready_seen++;
            @(posedge clk); #1; lat++;
        end
        checks++;
        if (lat !== 33) begin errors++; $display("FAIL mul_latency: got %0d required 33", lat); end
        checks++;
        if (ready_seen !== 0) begin errors++; $display("FAIL mul_in_ready: got %0d cycles high required 0", ready_seen); end
        checks++;
        if (Result !== 32'd8369910 || {Zero, Carry, Overflow, Negative} !== 4'b0000) begin
            errors++; $display("FAIL mul_result: got R=%0d ZCVN=%b required R=8369910 ZCVN=0000", Result, {Zero, Carry, Overflow, Negative});
        end
        release_out();
        issue(4'b1000, 32'h00010000, 32'h00010000);
        wait_done(lat);
        checks++;
        if (lat !== 33 || Result !== 32'h0 || Zero !== 1'b1) begin
            errors++; $display("FAIL mul_wrap_zero: got lat=%0d R=%h Z=%b required lat=33 R=0 Z=1", lat, Result, Zero);
        end
        release_out();
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        issue(4'b0001, 32'hF0F0F0F0, 32'hFF00FF00);
        wait_done(lat);
        bad = 0;
        in_valid = 1'b1; ALUControl = 4'b0000; A = 32'h1; B = 32'h1;
        for (int i = 0; i < 5; i++) begin
            if (Result !== 32'hF000F000 || out_valid !== 1'b1 || in_ready !== 1'b0 || Negative !== 1'b1) bad++;
            @(posedge clk); #1;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL backpressure_hold: got %0d bad cycles required 0 (R=%h)", bad, Result); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || Result !== 32'hF000F000) begin
            errors++; $display("FAIL no_bypass: got ov=%b ir=%b R=%h required ov=0 ir=1 R=f000f000", out_valid, in_ready, Result);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid_mul();
        int lat;
        issue(4'b1000, 32'd1000, 32'd1000);
        repeat (9) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, Result, Zero, Carry, Overflow, Negative} !== 37'd0) begin
            errors++; $display("FAIL reset_mid_mul: got %h required 0", {out_valid, Result, Zero, Carry, Overflow, Negative});
        end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        issue(4'b0000, 32'd2, 32'd3);
        wait_done(lat);
        checks++;
        if (lat !== 1 || Result !== 32'd5 || {Zero, Carry, Overflow, Negative} !== 4'b0000) begin
            errors++; $display("FAIL add_after_reset: got lat=%0d R=%0d required lat=1 R=5", lat, Result);
        end
        release_out();
        issue(4'b1000, 32'd7, 32'd9);
        wait_done(lat);
        checks++;
        if (lat !== 33 || Result !== 32'd63) begin
            errors++; $display("FAIL mul_after_reset: got lat=%0d R=%0d required lat=33 R=63", lat, Result);
        end
        release_out();
    endtask

    initial begin
        test_reset();
        test_add_carry();
        test_sub_slt();
        test_logic_shift();
        test_mul();
        test_backpressure();
        test_reset_mid_mul();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq_core.md
ALU_SEQ_CORE -- requirements
Module: alu_seq_core

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width (>=8, power of 2).
REQ-002 Parameter: SHW, default $clog2(WIDTH), shift-amount width taken from B[SHW-1:0].
REQ-003 Port: clk  in  1  single clock, all state on rising edge.
REQ-004 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Port: in_valid  in  1  operation request.
REQ-006 Port: in_ready  out  1  block can accept an operation.
REQ-007 Port: A  in  WIDTH  operand A.
REQ-008 Port: B  in  WIDTH  operand B.
REQ-009 Port: ALUControl  in  4  opcode.
REQ-010 Port: out_valid  out  1  Result/flags valid.
REQ-011 Port: out_ready  in  1  consumer takes result.
REQ-012 Port: Result  out  WIDTH  registered result.
REQ-013 Port: Zero, Carry, Overflow, Negative  out  1 each  registered flags.

Function
REQ-014 Opcodes: 0000 ADD, 0001 AND, 0010 OR, 0011 XOR, 0100 SUB, 0101 SLT (signed, result 1/0), 0110 SLL, 0111 SRL, 1000 MUL (low WIDTH bits of A*B, unsigned); all others illegal.
REQ-015 Handshake: operation accepted on rising edge with in_valid && in_ready; A, B, ALUControl captured then, ignored afterward.
REQ-016 FSM states IDLE, MUL, DONE; in_ready=1 only in IDLE.
REQ-017 IDLE + accept of non-MUL opcode -> DONE; Result/flags loaded same edge; out_valid=1 one cycle after accept.
REQ-018 IDLE + accept of MUL -> MUL; iterative shift-add, one multiplier bit per cycle, WIDTH cycles; then DONE; out_valid asserts WIDTH+1 cycles after accept.
REQ-019 DONE: Result/flags/out_valid held stable while out_ready=0; out_valid && out_ready -> IDLE next edge, out_valid drops.
REQ-020 No accept in DONE even if out_ready=1 same cycle (no back-to-back bypass); max throughput one op per 2 cycles.
REQ-021 Carry: ADD = carry-out of bit WIDTH-1; SUB/SLT = borrow (1 when A<B unsigned); 0 for all other ops.
REQ-022 Overflow: ADD/SUB signed overflow; 0 for all other ops.
REQ-023 Zero = (Result==0); Negative = Result[WIDTH-1]; both computed from final Result for every op incl. MUL.
REQ-024 Shifts: amount B[SHW-1:0], logical, zero-fill; amount 0 -> Result=A.
REQ-025 Illegal opcode: completes as single-cycle op, Result=0, Zero=1, other flags 0.
REQ-026 in_valid in non-IDLE states has no effect; requester must hold until in_ready.

Reset
REQ-027 rst_n low (any state, incl. mid-MUL): FSM->IDLE, Result=0, all flags=0, out_valid=0, multiplier state cleared, in operation discarded.
REQ-028 in_ready=1 from first rising edge after rst_n deasserts.

Structure
REQ-029 Shared package alu_pkg: opcode constants (4-bit) and FSM state typedef.
REQ-030 One sub-module alu_mul_iter: start/done, WIDTH-parametrised shift-add multiplier, own counter; remaining ops combinational inside alu_seq_core.
REQ-031 No combinational path from in_valid/A/B to Result or flags; all outputs registered except in_ready (decoded from state).

Verification (WIDTH=32)
REQ-032 ADD A=0xFFFFFFFF, B=1 -> one cycle after accept: Result=0, Zero=1, Carry=1, Overflow=0, Negative=0.
REQ-033 SUB A=0x80000000, B=1 -> Result=0x7FFFFFFF, Overflow=1, Carry=0, Negative=0; SLT A=0xFFFFFFFF, B=1 -> Result=1.
REQ-034 MUL A=12345, B=678 -> out_valid exactly 33 cycles after accept, Result=8369910, Zero=0; in_ready=0 throughout.
REQ-035 Backpressure: AND A=0xF0F0F0F0, B=0xFF00FF00, out_ready=0 for 5 cycles -> Result=0xF000F000 stable, out_valid=1, in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-036 rst_n low 10 cycles into MUL -> Result=0, flags=0, out_valid=0 immediately; after release a new ADD 2+3 returns 5 normally.
REQ-037 Opcode 1111 with A=B=0xFFFFFFFF -> Result=0, Zero=1, Carry=Overflow=Negative=0; SLL A=1, B=31 -> 0x80000000, Negative=1.
